// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the DA FIR LUT loader.
package fir_pkg;

    localparam int NUM_TAPS   = 64;
    localparam int GROUP_SIZE = 8;
    localparam int NUM_GROUPS = 8;
    localparam int LUT_DEPTH  = 2048;
    localparam int COEF_W     = 16;
    localparam int LUT_W      = 20;
    localparam int ADDR_W     = 11;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

endpackage

// File: rtl/fir_da_sum8.sv
// Masked sum of one 8-coefficient group: one distributed-arithmetic LUT entry.
module fir_da_sum8 #(
    parameter int COEF_W = fir_pkg::COEF_W,
    parameter int LUT_W  = fir_pkg::LUT_W
) (
    input  logic [COEF_W-1:0] coef [fir_pkg::GROUP_SIZE],
    input  logic [fir_pkg::GROUP_SIZE-1:0] mask,
    output logic [LUT_W-1:0]  sum
);
    import fir_pkg::*;

    // Size cast of a signed operand sign-extends; the add wraps at LUT_W.
    always_comb begin
        sum = '0;
        for (int i = 0; i < GROUP_SIZE; i++) begin
            if (mask[i]) begin
                sum = sum + LUT_W'($signed(coef[i]));
            end
        end
    end

endmodule

// File: rtl/fir_da_lut_loader.sv
// Coefficient file plus FSM that streams all DA partial-sum LUT entries
// into the filter, one entry every STRIDE cycles, then releases valid_in.
module fir_da_lut_loader #(
    parameter int NUM_TAPS = fir_pkg::NUM_TAPS,
    parameter int COEF_W   = fir_pkg::COEF_W,
    parameter int LUT_W    = fir_pkg::LUT_W,
    parameter int ADDR_W   = fir_pkg::ADDR_W,
    parameter int STRIDE   = 165
) (
    input  logic              clk_fast,
    input  logic              reset,
    input  logic              coef_we,
    input  logic [5:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    input  logic              start,
    output logic [LUT_W-1:0]  CIN,
    output logic [ADDR_W-1:0] CADDR,
    output logic              CLOAD,
    output logic              valid_in,
    output logic              busy,
    output logic              done,
    output logic              coef_err
);
    import fir_pkg::*;

    localparam int CNT_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STRIDE - 1);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(LUT_DEPTH - 1);

    state_t state_q, state_d;
    logic [COEF_W-1:0] coef_q [NUM_TAPS];
    logic [COEF_W-1:0] coef_d [NUM_TAPS];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LUT_W-1:0]  cin_q, cin_d;
    logic              cload_q, cload_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] addr_nxt;
    logic [COEF_W-1:0] grp [GROUP_SIZE];
    logic [LUT_W-1:0]  sum;

    // The entry for the next address is computed ahead and registered.
    assign addr_nxt = addr_q + ADDR_W'(1);

    always_comb begin
        for (int i = 0; i < GROUP_SIZE; i++) begin
            grp[i] = coef_q[{addr_nxt[ADDR_W-1 -: 3], 3'(i)}];
        end
    end

    fir_da_sum8 #(
        .COEF_W (COEF_W),
        .LUT_W  (LUT_W)
    ) u_sum8 (
        .coef (grp),
        .mask (addr_nxt[GROUP_SIZE-1:0]),
        .sum  (sum)
    );

    always_comb begin
        state_d = state_q;
        coef_d  = coef_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        cin_d   = cin_q;
        cload_d = cload_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE, RUN: begin
                if (coef_we) begin
                    coef_d[coef_addr] = coef_data;
                end
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    addr_d  = '0;
                    cin_d   = '0;
                    cload_d = 1'b1;
                    valid_d = 1'b0;
                end
            end
            LOAD: begin
                err_d = coef_we;
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (addr_q == LAST) begin
                        state_d = RUN;
                        cload_d = 1'b0;
                        valid_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        addr_d = addr_nxt;
                        cin_d  = sum;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_fast or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            coef_q  <= '{default: '0};
            cnt_q   <= '0;
            addr_q  <= '0;
            cin_q   <= '0;
            cload_q <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            coef_q  <= coef_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            cin_q   <= cin_d;
            cload_q <= cload_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign CIN      = cin_q;
    assign CADDR    = addr_q;
    assign CLOAD    = cload_q;
    assign valid_in = valid_q;
    assign busy     = (state_q == LOAD);
    assign done     = done_q;
    assign coef_err = err_q;

endmodule

// File: tb/tb_fir_da_lut_loader.sv
// Scoreboard bench for fir_da_lut_loader: expected LUT entries are pushed
// at start and popped as each new CADDR appears on the load bus.
module tb_fir_da_lut_loader;

    localparam int STRIDE = 2;
    localparam int DEPTH  = 2048;

    logic        clk_fast = 1'b0;
    logic        reset = 1'b1;
    logic        coef_we = 1'b0;
    logic [5:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic        start = 1'b0;
    logic [19:0] CIN;
    logic [10:0] CADDR;
    logic        CLOAD, valid_in, busy, done, coef_err;

    fir_da_lut_loader #(.STRIDE(STRIDE)) dut (
        .clk_fast  (clk_fast),
        .reset     (reset),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .start     (start),
        .CIN       (CIN),
        .CADDR     (CADDR),
        .CLOAD     (CLOAD),
        .valid_in  (valid_in),
        .busy      (busy),
        .done      (done),
        .coef_err  (coef_err)
    );

    always #5 clk_fast = ~clk_fast;

    typedef struct {
        int addr;
        int cin;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cm[64];
    int   seen[DEPTH];
    int   edge_cnt = 0;

    always @(posedge clk_fast) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model(input int a);
        int g;
        int s;
        g = a >> 8;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            if (((a >> i) & 1) == 1) s += cm[8 * g + i];
        end
        return s & 32'hFFFFF;
    endfunction

    // Bus monitor: one scoreboard pop per new entry, hold-time check per entry.
    initial begin
        bit   pcl;
        int   paddr;
        int   hold;
        int   last_cin;
        ent_t e;
        pcl = 0;
        paddr = 0;
        hold = 0;
        last_cin = 0;
        forever begin
            @(negedge clk_fast);
            if (reset) begin
                pcl = 0;
                hold = 0;
            end else begin
                if (CLOAD && (!pcl || int'(CADDR) != paddr)) begin
                    if (pcl) check("hold", hold, STRIDE);
                    if (sb.size() == 0) begin
                        check("sb_underflow", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("caddr", CADDR, e.addr);
                        check("cin", CIN, e.cin);
                    end
                    seen[CADDR] = int'(CIN);
                    hold = 1;
                end else if (CLOAD) begin
                    hold++;
                end else if (pcl) begin
                    check("hold_last", hold, STRIDE);
                    check("done_edge", done, 1);
                    check("valid_edge", valid_in, 1);
                    check("caddr_last", CADDR, DEPTH - 1);
                    check("cin_last", CIN, last_cin);
                end
                pcl = CLOAD;
                paddr = int'(CADDR);
                if (CLOAD) last_cin = int'(CIN);
            end
        end
    end

    task automatic wr(input int a, input int d);
        @(negedge clk_fast);
        coef_we = 1'b1;
        coef_addr = a[5:0];
        coef_data = d[15:0];
        cm[a] = d;
        @(negedge clk_fast);
        coef_we = 1'b0;
        check("wr_no_err", coef_err, 0);
    endtask

    task automatic do_start(input bit w, input int a, input int d,
                            output int e0);
        @(negedge clk_fast);
        e0 = edge_cnt + 1;
        start = 1'b1;
        if (w) begin
            coef_we = 1'b1;
            coef_addr = a[5:0];
            coef_data = d[15:0];
            cm[a] = d;
        end
        for (int i = 0; i < DEPTH; i++) begin
            sb.push_back('{addr: i, cin: model(i)});
        end
        @(negedge clk_fast);
        start = 1'b0;
        coef_we = 1'b0;
        check("st_cload", CLOAD, 1);
        check("st_valid", valid_in, 0);
        check("st_busy", busy, 1);
        check("st_caddr", CADDR, 0);
        check("st_cin", CIN, 0);
    endtask

    task automatic wait_done(input int e0);
        bit got;
        got = 0;
        for (int n = 0; n < 6000 && !got; n++) begin
            @(negedge clk_fast);
            if (done) got = 1;
        end
        if (!got) begin
            check("done_timeout", 0, 1);
        end else begin
            check("done_lat", edge_cnt - e0, DEPTH * STRIDE);
            @(negedge clk_fast);
            check("done_1cyc", done, 0);
            check("run_valid", valid_in, 1);
            check("run_busy", busy, 0);
            check("run_cload", CLOAD, 0);
        end
    endtask

    initial begin
        int  e0;
        bit  hit;
        for (int i = 0; i < 64; i++) cm[i] = 0;
        for (int i = 0; i < DEPTH; i++) seen[i] = -1;

        repeat (2) @(negedge clk_fast);
        check("rst_cin", CIN, 0);
        check("rst_caddr", CADDR, 0);
        check("rst_cload", CLOAD, 0);
        check("rst_valid", valid_in, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", coef_err, 0);
        reset = 1'b0;

        // All coefficients 1
        for (int i = 0; i < 64; i++) wr(i, 1);
        do_start(0, 0, 0, e0);
        wait_done(e0);
        check("ones_003", seen['h003], 2);
        check("ones_0ff", seen['h0FF], 8);
        check("ones_1ff", seen['h1FF], 8);
        check("ones_100", seen['h100], 0);

        // coef[i] = i, last write lands together with the reload start
        for (int i = 0; i < 63; i++) wr(i, i);
        do_start(1, 63, 63, e0);
        repeat (100) @(negedge clk_fast);
        start = 1'b1;
        @(negedge clk_fast);
        start = 1'b0;
        repeat (100) @(negedge clk_fast);
        coef_we = 1'b1;
        coef_addr = 6'd63;
        coef_data = 16'd1000;
        @(negedge clk_fast);
        coef_we = 1'b0;
        check("err_pulse", coef_err, 1);
        @(negedge clk_fast);
        check("err_once", coef_err, 0);
        wait_done(e0);
        check("idx_0ff", seen['h0FF], 28);
        check("idx_7ff", seen['h7FF], 476);
        check("idx_781", seen['h781], 119);

        // Most-negative coefficients in group 0
        for (int i = 0; i < 8; i++) wr(i, -32768);
        do_start(0, 0, 0, e0);
        wait_done(e0);
        check("neg_0ff", seen['h0FF], 'hC0000);
        check("neg_001", seen['h001], 'hF8000);

        // Asynchronous reset in the middle of a load
        do_start(0, 0, 0, e0);
        hit = 0;
        for (int n = 0; n < 3000 && !hit; n++) begin
            @(negedge clk_fast);
            if (CADDR == 11'd500) hit = 1;
        end
        check("reach_500", hit, 1);
        #2 reset = 1'b1;
        #1;
        check("ar_cin", CIN, 0);
        check("ar_caddr", CADDR, 0);
        check("ar_cload", CLOAD, 0);
        check("ar_valid", valid_in, 0);
        check("ar_busy", busy, 0);
        sb.delete();
        for (int i = 0; i < 64; i++) cm[i] = 0;
        for (int i = 0; i < DEPTH; i++) seen[i] = -1;
        @(negedge clk_fast);
        reset = 1'b0;
        do_start(0, 0, 0, e0);
        wait_done(e0);
        check("zero_0ff", seen['h0FF], 0);
        check("zero_7ff", seen['h7FF], 0);
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
